a2d_conv_scheduler: RTL and testbench
=====================================

// Module: a2d_conv_scheduler
// PURPOSE
//  Round-robin scheduler for the shared A2D SPI master (ADC128S on A2D_SS_n/SCLK/MOSI/MISO).
//  - Each nxt strobe (from inertial vld) triggers one conversion.
//  - Channel order: left load cell, right load cell, steer pot, battery.
//  - Each conversion is two 16-bit SPI transactions: select channel, then read result.
//  - Holds the latest 12-bit result per channel for the balance/steer/safety logic.
// PARAMETERS
//  CH_LFT      3'd0  ADC channel of left load cell
//  CH_RGHT     3'd4  ADC channel of right load cell
//  CH_STEER    3'd5  ADC channel of steering pot
//  CH_BATT     3'd6  ADC channel of battery
//  GAP_CYCLES  2     idle clocks between the two transactions (range 1..15)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  nxt          in   1   1-clk strobe: start next conversion
//  spi_wrt      out  1   1-clk strobe to SPI master: start transaction
//  spi_cmd      out  16  word shifted out on MOSI
//  spi_done     in   1   1-clk strobe from SPI master: transaction finished
//  spi_rd_data  in   16  word shifted in on MISO; valid when spi_done=1
//  lft_ld       out  12  latest left load-cell result
//  rght_ld      out  12  latest right load-cell result
//  steer_pot    out  12  latest steering-pot result
//  batt         out  12  latest battery result
//  busy         out  1   high from nxt acceptance until result latched
//  conv_vld     out  1   1-clk pulse: a result register just updated
//  conv_ch      out  2   index of the updated register (0 lft,1 rght,2 steer,3 batt)
//  nxt_ovr      out  1   1-clk pulse: nxt arrived while busy and was dropped
// BEHAVIOUR
//  Reset values
//  - All outputs are 0; state is IDLE; round-robin pointer rr=0 (lft).
//  - Reset mid-conversion aborts immediately: no latch and no conv_vld; SPI master reset is separate.
//  - spi_cmd = {2'b00, ch[2:0], 11'h000}; ch = channel parameter selected by rr.
//    spi_cmd is registered and held stable from the spi_wrt cycle until the next spi_wrt.
//  States
//  - IDLE: nxt=1 -> SEL; busy=1 next clk.
//  - SEL: spi_wrt=1 for exactly one clk -> WAIT1.
//  - WAIT1: on spi_done -> GAP; spi_rd_data discarded.
//  - GAP: count GAP_CYCLES clks -> RD.
//  - RD: spi_wrt=1 one clk, spi_cmd unchanged -> WAIT2.
//  - WAIT2: on spi_done -> LATCH.
//  - LATCH: perform the update and pulse listed below in one clk -> IDLE.
//    - result[rr] <= spi_rd_data[11:0]; upper 4 bits are ignored.
//    - conv_vld=1 and conv_ch=rr.
//    - rr <= rr+1; 2-bit wrap 3->0.
//    - busy=0 on the following clk.
//  Handshake and timing
//  - Latency: nxt at clk N -> spi_wrt at N+2.
//  - Only one register changes per conversion; the other three hold.
//  - spi_done is ignored outside WAIT1/WAIT2, including the cycle spi_wrt is high.
//  - nxt while busy=1, including the LATCH clk, is dropped and pulses nxt_ovr the next clk.
//  - nxt is never queued, and rr does not advance for a dropped nxt.
//  - nxt in the same clk LATCH returns to IDLE is an overrun; the next conversion needs a later nxt.
//  - No timeout: WAIT1/WAIT2 hold until spi_done or rst.
// TESTING
//  1. rst=1 for 2 clks -> all results 0, spi_wrt=0, busy=0, conv_ch=0; hold nxt=0 1000 clks -> no spi_wrt.
//  2. One nxt; model SPI with spi_done 40 clks after each spi_wrt; MISO 16'hF123 on the read
//     -> spi_cmd=16'h0000 on both wrts, wrts 1+40+GAP_CYCLES clks apart, lft_ld=12'h123.
//     -> conv_vld with conv_ch=0; others still 0.
//  3. Four nxts, each after busy falls; ADC values 330,330,2048,3000
//     -> spi_cmd sequence 0000,2000,2800,3000 (each twice).
//     -> lft_ld=330, rght_ld=330, steer_pot=2048, batt=3000; fifth nxt selects 16'h0000 again.
//  4. nxt pulsed in WAIT1 and again in LATCH clk -> two nxt_ovr pulses; rr advances once; no extra spi_wrt.
//  5. rst asserted in WAIT2 -> next clk IDLE, spi_wrt=0, no conv_vld, results 0; following nxt issues 16'h0000.
//  6. spi_done pulsed in IDLE and GAP -> no state change, no latch.
//     Pass/fail via assertions on busy, spi_wrt width==1 clk, and one-hot result updates.

Source files
------------

// File: rtl/a2d_conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_conv_scheduler
//  Description : Round-robin conversion scheduler for the shared ADC128S SPI
//                master. Each nxt strobe runs one two-transaction conversion
//                (channel select, then result read) on the next channel in
//                the order left load cell, right load cell, steer pot,
//                battery, and keeps the latest 12-bit result per channel.
//  Revision    : 1.0  initial release
// ============================================================================
module a2d_conv_scheduler #(
    parameter logic [2:0]  CH_LFT     = 3'd0,
    parameter logic [2:0]  CH_RGHT    = 3'd4,
    parameter logic [2:0]  CH_STEER   = 3'd5,
    parameter logic [2:0]  CH_BATT    = 3'd6,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        conv_vld,
    output logic [1:0]  conv_ch,
    output logic        nxt_ovr
);

    localparam logic [3:0] c_GAP_LOAD = 4'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_WAIT1 = 3'd2,
        S_GAP   = 3'd3,
        S_RD    = 3'd4,
        S_WAIT2 = 3'd5,
        S_LATCH = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_spi_wrt;
    logic [15:0] r_spi_cmd;
    logic [1:0]  r_rr;
    logic [3:0]  r_gap_cnt;
    logic [11:0] r_lft_ld;
    logic [11:0] r_rght_ld;
    logic [11:0] r_steer_pot;
    logic [11:0] r_batt;
    logic        r_conv_vld;
    logic [1:0]  r_conv_ch;
    logic        r_nxt_ovr;

    logic        w_issue;     // launch an SPI transaction next clock
    logic        w_gap_load;  // first transaction finished, start gap count
    logic        w_latch;     // read transaction finished, capture result
    logic        w_gap_last;
    logic [2:0]  w_ch;

    // The upper MISO bits carry no conversion data.
    logic        w_unused_rd_hi;
    assign w_unused_rd_hi = |spi_rd_data[15:12];

    assign w_gap_last = (r_gap_cnt <= 4'd1);

    // Map the round-robin pointer onto the physical ADC channel.
    always_comb begin
        w_ch = CH_BATT;
        case (r_rr)
            2'd0:    w_ch = CH_LFT;
            2'd1:    w_ch = CH_RGHT;
            2'd2:    w_ch = CH_STEER;
            default: w_ch = CH_BATT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode. spi_wrt is registered, so the launch is requested one
    // clock ahead: from SEL for the select word and from the last gap clock
    // for the read word, which keeps exactly GAP_CYCLES idle clocks between
    // the first spi_done and the second spi_wrt.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_gap_load  = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (nxt) begin
                    w_state_nxt = S_SEL;
                end
            end
            S_SEL: begin
                w_issue     = 1'b1;
                w_state_nxt = S_WAIT1;
            end
            S_WAIT1: begin
                // spi_done during the launch clock belongs to no transaction.
                if (spi_done && !r_spi_wrt) begin
                    w_gap_load  = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_last) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                w_state_nxt = S_WAIT2;
            end
            S_WAIT2: begin
                if (spi_done) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered SPI handshake, gap counter, result registers and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spi_wrt   <= 1'b0;
            r_spi_cmd   <= 16'h0000;
            r_rr        <= 2'd0;
            r_gap_cnt   <= 4'd0;
            r_lft_ld    <= 12'h000;
            r_rght_ld   <= 12'h000;
            r_steer_pot <= 12'h000;
            r_batt      <= 12'h000;
            r_conv_vld  <= 1'b0;
            r_conv_ch   <= 2'd0;
            r_nxt_ovr   <= 1'b0;
        end else begin
            r_spi_wrt  <= w_issue;
            r_conv_vld <= w_latch;
            r_nxt_ovr  <= nxt && (r_state != S_IDLE);

            if (r_state == S_SEL) begin
                r_spi_cmd <= {2'b00, w_ch, 11'h000};
            end

            if (w_gap_load) begin
                r_gap_cnt <= c_GAP_LOAD;
            end else if ((r_state == S_GAP) && !w_gap_last) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end

            if (w_latch) begin
                r_conv_ch <= r_rr;
                case (r_rr)
                    2'd0:    r_lft_ld    <= spi_rd_data[11:0];
                    2'd1:    r_rght_ld   <= spi_rd_data[11:0];
                    2'd2:    r_steer_pot <= spi_rd_data[11:0];
                    default: r_batt      <= spi_rd_data[11:0];
                endcase
            end

            if (r_state == S_LATCH) begin
                r_rr <= r_rr + 2'd1;
            end
        end
    end

    assign spi_wrt   = r_spi_wrt;
    assign spi_cmd   = r_spi_cmd;
    assign lft_ld    = r_lft_ld;
    assign rght_ld   = r_rght_ld;
    assign steer_pot = r_steer_pot;
    assign batt      = r_batt;
    assign busy      = (r_state != S_IDLE);
    assign conv_vld  = r_conv_vld;
    assign conv_ch   = r_conv_ch;
    assign nxt_ovr   = r_nxt_ovr;

endmodule
`default_nettype wire

// File: tb/tb_a2d_conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a2d_conv_scheduler
//  Description : Directed self-checking bench for a2d_conv_scheduler with a
//                simple SPI master responder (spi_done 40 clks after spi_wrt).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_a2d_conv_scheduler;

    localparam int c_GAP = 2;

    logic        clk;
    logic        rst;
    logic        nxt;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        busy;
    logic        conv_vld;
    logic [1:0]  conv_ch;
    logic        nxt_ovr;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [11:0] exp_res [4];

    a2d_conv_scheduler #(
        .CH_LFT     (3'd0),
        .CH_RGHT    (3'd4),
        .CH_STEER   (3'd5),
        .CH_BATT    (3'd6),
        .GAP_CYCLES (c_GAP)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .nxt         (nxt),
        .spi_wrt     (spi_wrt),
        .spi_cmd     (spi_cmd),
        .spi_done    (spi_done),
        .spi_rd_data (spi_rd_data),
        .lft_ld      (lft_ld),
        .rght_ld     (rght_ld),
        .steer_pot   (steer_pot),
        .batt        (batt),
        .busy        (busy),
        .conv_vld    (conv_vld),
        .conv_ch     (conv_ch),
        .nxt_ovr     (nxt_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_res[i] = 12'h000;
    endtask

    function automatic logic [11:0] result_of(input int ch);
        case (ch)
            0:       return lft_ld;
            1:       return rght_ld;
            2:       return steer_pot;
            default: return batt;
        endcase
    endfunction

    task automatic check_results(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_res%0d", tag, i), {20'h0, result_of(i)}, {20'h0, exp_res[i]});
        end
    endtask

    task automatic issue_nxt();
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
    endtask

    // Advance until spi_wrt is seen; returns the cycle index.
    task automatic wait_wrt(input string tag, output int t);
        bit ok;
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 200; i++) begin
            if (spi_wrt) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
            tick();
        end
        if (!ok) check({tag, "_wrt_timeout"}, 32'd0, 32'd1);
    endtask

    // Called in the spi_wrt clock; answers with spi_done 40 clocks later.
    // Optionally drives a stray spi_done in the launch clock and an nxt
    // while the transaction is outstanding.
    task automatic spi_reply(input logic [15:0] data, input bit stray, input bit pulse_nxt);
        for (int i = 1; i <= 40; i++) begin
            spi_done    = stray && (i == 1);
            spi_rd_data = (stray && (i == 1)) ? 16'h0BAD : 16'h0000;
            nxt         = pulse_nxt && (i == 2);
            tick();
            if (i == 1) check("wrt_width", {31'h0, spi_wrt}, 32'd0);
            if (pulse_nxt && (i == 2)) check("ovr_wait", {31'h0, nxt_ovr}, 32'd1);
        end
        nxt         = 1'b0;
        spi_done    = 1'b1;
        spi_rd_data = data;
        tick();
        spi_done    = 1'b0;
        spi_rd_data = 16'h0000;
    endtask

    // One full conversion with timing, command and result checks.
    task automatic conv(input logic [15:0] data, input logic [15:0] exp_cmd, input int exp_ch,
                        input bit stray, input bit ovr_wait, input bit ovr_latch);
        int n, t1, t2, nw;
        n = cyc;
        issue_nxt();
        check("busy_up", {31'h0, busy}, 32'd1);
        wait_wrt("sel", t1);
        check("latency", t1 - n, 32'd2);
        check("cmd_sel", {16'h0, spi_cmd}, {16'h0, exp_cmd});
        spi_reply(data ^ 16'h0FFF, stray, ovr_wait);
        if (stray) begin
            spi_done    = 1'b1;
            spi_rd_data = 16'h0777;
            tick();
            spi_done    = 1'b0;
            spi_rd_data = 16'h0000;
        end
        wait_wrt("rd", t2);
        check("wrt_gap", t2 - t1, 32'(41 + c_GAP));
        check("cmd_rd", {16'h0, spi_cmd}, {16'h0, exp_cmd});
        spi_reply(data, stray, 1'b0);
        exp_res[exp_ch] = data[11:0];
        check("conv_vld", {31'h0, conv_vld}, 32'd1);
        check("conv_ch", {30'h0, conv_ch}, exp_ch);
        check_results("latch");
        nxt = ovr_latch;
        tick();
        nxt = 1'b0;
        check("busy_down", {31'h0, busy}, 32'd0);
        check("vld_pulse", {31'h0, conv_vld}, 32'd0);
        check("ovr_latch", {31'h0, nxt_ovr}, {31'h0, ovr_latch});
        if (ovr_latch) begin
            nw = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (spi_wrt || busy) nw++;
            end
            check("dropped_nxt_idle", nw, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, t;
        rst         = 1'b1;
        nxt         = 1'b0;
        spi_done    = 1'b0;
        spi_rd_data = 16'h0000;

        // Reset state and idle behaviour.
        do_reset();
        check("rst_wrt", {31'h0, spi_wrt}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_ch", {30'h0, conv_ch}, 32'd0);
        check("rst_cmd", {16'h0, spi_cmd}, 32'd0);
        check_results("rst");
        nw = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (spi_wrt) nw++;
        end
        check("idle_no_wrt", nw, 32'd0);

        // Single conversion on the left load cell.
        conv(16'hF123, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        check("lft_f123", {20'h0, lft_ld}, 32'h123);

        // Full rotation with upper-bit junk on MISO, then wrap to left.
        do_reset();
        conv(16'hF14A, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        conv(16'hA14A, 16'h2000, 1, 1'b0, 1'b0, 1'b0);
        conv(16'h5800, 16'h2800, 2, 1'b0, 1'b0, 1'b0);
        conv(16'h3BB8, 16'h3000, 3, 1'b0, 1'b0, 1'b0);
        check("rot_lft", {20'h0, lft_ld}, 32'd330);
        check("rot_rght", {20'h0, rght_ld}, 32'd330);
        check("rot_steer", {20'h0, steer_pot}, 32'd2048);
        check("rot_batt", {20'h0, batt}, 32'd3000);

        // Wrapped conversion with overruns in WAIT1 and LATCH; rr advances once.
        conv(16'h0ABC, 16'h0000, 0, 1'b0, 1'b1, 1'b1);
        conv(16'h0111, 16'h2000, 1, 1'b0, 1'b0, 1'b0);

        // Stray spi_done while idle is ignored.
        spi_done    = 1'b1;
        spi_rd_data = 16'h0FFF;
        tick();
        spi_done    = 1'b0;
        spi_rd_data = 16'h0000;
        check("stray_idle_busy", {31'h0, busy}, 32'd0);
        check("stray_idle_vld", {31'h0, conv_vld}, 32'd0);
        tick();
        check("stray_idle_wrt", {31'h0, spi_wrt}, 32'd0);
        check_results("stray_idle");

        // Stray spi_done in launch clocks and in GAP is ignored.
        conv(16'h0222, 16'h2800, 2, 1'b1, 1'b0, 1'b0);

        // Reset while waiting for the read word aborts with no latch.
        issue_nxt();
        wait_wrt("abort_sel", t);
        spi_reply(16'h0000, 1'b0, 1'b0);
        wait_wrt("abort_rd", t);
        tick();
        check("abort_in_wait2", {31'h0, busy}, 32'd1);
        rst         = 1'b1;
        spi_done    = 1'b1;
        spi_rd_data = 16'h0FFF;
        tick();
        rst         = 1'b0;
        spi_done    = 1'b0;
        spi_rd_data = 16'h0000;
        for (int i = 0; i < 4; i++) exp_res[i] = 12'h000;
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_wrt", {31'h0, spi_wrt}, 32'd0);
        check("abort_vld", {31'h0, conv_vld}, 32'd0);
        check_results("abort");
        tick();
        check("abort_vld_late", {31'h0, conv_vld}, 32'd0);
        conv(16'h0345, 16'h0000, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
